// File: rtl/post_cn_scheduler_if.sv
// Bundle of request, post_CN and result signals for post_cn_scheduler.
// The slave modport is the scheduler's view; master is the cores/post_CN/sink view.
interface post_cn_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int STATE_W = 1600,
    parameter int NONCE_W = 7,
    parameter int CNT_W   = 3
);
    logic [N_REQ-1:0]         i_req_valid;
    logic [N_REQ-1:0]         o_req_ready;
    logic [N_REQ*STATE_W-1:0] i_req_data;
    logic [N_REQ*NONCE_W-1:0] i_req_nonce;
    logic                     o_pc_valid;
    logic                     i_pc_ready;
    logic [STATE_W-1:0]       o_pc_data;
    logic [NONCE_W-1:0]       o_pc_nonce;
    logic                     i_pc_valid;
    logic                     o_pc_ready;
    logic [255:0]             i_pc_result;
    logic [63:0]              i_target;
    logic                     o_valid;
    logic                     i_ready;
    logic [255:0]             o_result;
    logic [NONCE_W-1:0]       o_nonce;
    logic [ID_W-1:0]          o_src_id;
    logic                     o_found;
    logic [CNT_W-1:0]         o_inflight;
    logic                     o_err;

    modport slave (
        input  i_req_valid, i_req_data, i_req_nonce, i_pc_ready, i_pc_valid,
               i_pc_result, i_target, i_ready,
        output o_req_ready, o_pc_valid, o_pc_data, o_pc_nonce, o_pc_ready,
               o_valid, o_result, o_nonce, o_src_id, o_found, o_inflight, o_err
    );

    modport master (
        output i_req_valid, i_req_data, i_req_nonce, i_pc_ready, i_pc_valid,
               i_pc_result, i_target, i_ready,
        input  o_req_ready, o_pc_valid, o_pc_data, o_pc_nonce, o_pc_ready,
               o_valid, o_result, o_nonce, o_src_id, o_found, o_inflight, o_err
    );
endinterface

// File: rtl/post_cn_scheduler.sv
// Round-robin sharing of one post_CN pipeline among N_REQ cores, with in-order tag FIFO.
// Optional macro POST_CN_SCHED_FOUND_FILTER_EN: only found results reach the output.
module post_cn_scheduler #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int STATE_W      = 1600,
    parameter int NONCE_W      = 7,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input logic               clk,
    input logic               rstn,
    post_cn_scheduler_if.slave bus
);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic {S_IDLE, S_ISSUE} issue_state_t;

    issue_state_t       state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, winner, idx;
    logic               grant_any, slot_free, push, pop, drop, found_now, keep;
    logic [N_REQ-1:0]   grant;
    logic [NONCE_W-1:0] fifo_nonce [MAX_INFLIGHT];
    logic [ID_W-1:0]    fifo_id    [MAX_INFLIGHT];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [STATE_W-1:0] pc_data;
    logic [NONCE_W-1:0] pc_nonce;
    logic               res_valid, res_found, err;
    logic [255:0]       res_data;
    logic [NONCE_W-1:0] res_nonce;
    logic [ID_W-1:0]    res_src;

    // Issue pulse FSM: one cycle in S_ISSUE after every accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = push ? S_ISSUE : S_IDLE;
    end

    always_comb begin
        bus.o_pc_valid = (state == S_ISSUE);
    end

    assign slot_free = (state == S_IDLE) && bus.i_pc_ready && (count < CNT_W'(MAX_INFLIGHT));

    always_comb begin
        winner    = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_any && bus.i_req_valid[idx]) begin
                grant_any = 1'b1;
                winner    = idx;
            end
        end
    end

    // Ready is forced low while reset is held so every output reads 0.
    assign grant = (rstn && slot_free && grant_any) ? (N_REQ'(1) << winner) : '0;
    assign push  = |grant;

    assign bus.o_pc_ready = rstn && !res_valid;
    assign pop       = bus.i_pc_valid && bus.o_pc_ready && (count != '0);
    assign drop      = bus.i_pc_valid && bus.o_pc_ready && (count == '0);
    assign found_now = bus.i_pc_result[255:192] < bus.i_target;
`ifdef POST_CN_SCHED_FOUND_FILTER_EN
    assign keep = found_now;
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_nonce[wr_ptr] <= bus.i_req_nonce[winner*NONCE_W +: NONCE_W];
            fifo_id[wr_ptr]    <= winner;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= ID_W'(N_REQ - 1);
            pc_data   <= '0;
            pc_nonce  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_nonce <= '0;
            res_src   <= '0;
            res_found <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr   <= winner;
                pc_data  <= bus.i_req_data[winner*STATE_W +: STATE_W];
                pc_nonce <= bus.i_req_nonce[winner*NONCE_W +: NONCE_W];
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                res_data  <= bus.i_pc_result;
                res_nonce <= fifo_nonce[rd_ptr];
                res_src   <= fifo_id[rd_ptr];
                res_found <= found_now;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop && keep)      res_valid <= 1'b1;
            else if (bus.i_ready) res_valid <= 1'b0;
            if (drop) err <= 1'b1;
        end
    end

    assign bus.o_req_ready = grant;
    assign bus.o_pc_data   = pc_data;
    assign bus.o_pc_nonce  = pc_nonce;
    assign bus.o_valid     = res_valid;
    assign bus.o_result    = res_data;
    assign bus.o_nonce     = res_nonce;
    assign bus.o_src_id    = res_src;
    assign bus.o_found     = res_found;
    assign bus.o_inflight  = count;
    assign bus.o_err       = err;
endmodule

// File: tb/tb_post_cn_scheduler.sv
// Self-checking bench for post_cn_scheduler: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_post_cn_scheduler;
    localparam int N_REQ        = 4;
    localparam int ID_W         = 2;
    localparam int STATE_W      = 1600;
    localparam int NONCE_W      = 7;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    post_cn_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W), .STATE_W(STATE_W),
                           .NONCE_W(NONCE_W), .CNT_W(CNT_W)) bus ();

    post_cn_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .STATE_W(STATE_W), .NONCE_W(NONCE_W),
                        .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W))
        dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct { logic [NONCE_W-1:0] nonce; int id; } tag_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Staged stimulus, applied to the DUT at the next falling edge
    logic [N_REQ-1:0]   valid_s;
    logic [STATE_W-1:0] core_data  [N_REQ];
    logic [NONCE_W-1:0] core_nonce [N_REQ];
    logic               pcr_s, pcv_s, rdy_s;
    logic [255:0]       res_s;
    logic [63:0]        tgt_s;

    // Reference model
    int                 m_ptr;
    tag_t               m_q[$];
    bit                 m_pulse, m_ov, m_err, m_found;
    logic [STATE_W-1:0] m_iss_data;
    logic [NONCE_W-1:0] m_iss_nonce, m_nonce;
    logic [255:0]       m_res;
    int                 m_src;
    int                 last_grant;
    bit                 last_pc_taken;
    int                 grants[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [STATE_W-1:0] rand_state();
        logic [STATE_W-1:0] s;
        for (int i = 0; i < STATE_W / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [255:0] rand_result(input logic [63:0] t);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
            0:       r[255:192] = t - 64'($urandom_range(0, 2));
            1:       r[255:192] = t + 64'($urandom_range(0, 2));
            default: ;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = N_REQ - 1;
        m_q.delete();
        m_pulse = 0; m_ov = 0; m_err = 0; m_found = 0;
        m_iss_data = '0; m_iss_nonce = '0; m_nonce = '0; m_res = '0; m_src = 0;
        last_grant = -1; last_pc_taken = 0;
    endtask

    task automatic clear_inputs();
        valid_s = '0; pcr_s = 1'b1; pcv_s = 1'b0; rdy_s = 1'b1; res_s = '0; tgt_s = '0;
        for (int i = 0; i < N_REQ; i++) begin core_data[i] = '0; core_nonce[i] = '0; end
        bus.i_req_valid = '0; bus.i_req_data = '0; bus.i_req_nonce = '0;
        bus.i_pc_ready = 1'b0; bus.i_pc_valid = 1'b0; bus.i_pc_result = '0;
        bus.i_target = '0; bus.i_ready = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, bus.o_req_ready, '0);
        check({tag, "_pc_valid"},  bus.o_pc_valid, '0);
        check({tag, "_pc_ready"},  bus.o_pc_ready, '0);
        check({tag, "_pc_nonce"},  bus.o_pc_nonce, '0);
        check({tag, "_pc_data"},   bus.o_pc_data[255:0], '0);
        check({tag, "_valid"},     bus.o_valid, '0);
        check({tag, "_result"},    bus.o_result, '0);
        check({tag, "_nonce"},     bus.o_nonce, '0);
        check({tag, "_src"},       bus.o_src_id, '0);
        check({tag, "_found"},     bus.o_found, '0);
        check({tag, "_inflight"},  bus.o_inflight, '0);
        check({tag, "_err"},       bus.o_err, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        model_reset();
        #1 reset_checks("rst");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock: apply staged inputs, compare against the model, then advance the model.
    task automatic cycle();
        int   w;
        bit   slot_free, fnd;
        tag_t t;
        logic [N_REQ-1:0] exp_ready;
        @(negedge clk);
        bus.i_req_valid = valid_s;
        for (int i = 0; i < N_REQ; i++) begin
            bus.i_req_data[i*STATE_W +: STATE_W]  = core_data[i];
            bus.i_req_nonce[i*NONCE_W +: NONCE_W] = core_nonce[i];
        end
        bus.i_pc_ready = pcr_s; bus.i_pc_valid = pcv_s; bus.i_pc_result = res_s;
        bus.i_target = tgt_s; bus.i_ready = rdy_s;
        #1;
        slot_free = !m_pulse && pcr_s && (m_q.size() < MAX_INFLIGHT);
        w = -1;
        if (slot_free)
            for (int k = 1; k <= N_REQ; k++) begin
                int i = (m_ptr + k) % N_REQ;
                if (w < 0 && valid_s[i]) w = i;
            end
        exp_ready = (w >= 0) ? (N_REQ'(1) << w) : '0;
        check("req_ready", bus.o_req_ready, exp_ready);
        check("pc_valid", bus.o_pc_valid, m_pulse);
        if (m_pulse) begin
            check("pc_nonce", bus.o_pc_nonce, m_iss_nonce);
            check("pc_data_lo", bus.o_pc_data[255:0], m_iss_data[255:0]);
            check("pc_data_hi", bus.o_pc_data[STATE_W-1 -: 256], m_iss_data[STATE_W-1 -: 256]);
        end
        check("inflight", bus.o_inflight, m_q.size());
        check("valid", bus.o_valid, m_ov);
        check("pc_ready", bus.o_pc_ready, !m_ov);
        check("err", bus.o_err, m_err);
        if (m_ov) begin
            check("result", bus.o_result, m_res);
            check("nonce", bus.o_nonce, m_nonce);
            check("src_id", bus.o_src_id, m_src);
            check("found", bus.o_found, m_found);
        end
        last_pc_taken = pcv_s && !m_ov;
        if (last_pc_taken) begin
            if (m_q.size() > 0) begin
                t = m_q.pop_front();
                fnd = res_s[255:192] < tgt_s;
`ifdef POST_CN_SCHED_FOUND_FILTER_EN
                if (fnd) begin
`else
                begin
`endif
                    m_ov = 1; m_res = res_s; m_nonce = t.nonce; m_src = t.id; m_found = fnd;
                end
            end else m_err = 1;
        end else if (m_ov && rdy_s) m_ov = 0;
        if (w >= 0) begin
            t.nonce = core_nonce[w]; t.id = w;
            m_q.push_back(t);
            m_ptr = w;
            m_iss_data = core_data[w];
            m_iss_nonce = core_nonce[w];
            grants.push_back(w);
        end
        m_pulse = (w >= 0);
        last_grant = w;
    endtask

    task automatic issue_one(input int core, input logic [NONCE_W-1:0] nonce);
        bit got = 0;
        valid_s[core] = 1'b1; core_nonce[core] = nonce; core_data[core] = rand_state();
        for (int n = 0; n < 10 && !got; n++) begin
            cycle();
            if (last_grant == core) got = 1;
        end
        valid_s[core] = 1'b0;
        check("issue_timeout", got, 1'b1);
    endtask

    task automatic get_result(input logic [255:0] r);
        pcv_s = 1'b1; res_s = r;
        cycle();
        pcv_s = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        clear_inputs();
        model_reset();
        #12 reset_checks("por");
        @(negedge clk);
        rstn = 1'b1;

        // Single request from core 2
        valid_s = 4'b0100; core_nonce[2] = 7'h15; core_data[2] = rand_state();
        cycle();
        check("t1_ready", bus.o_req_ready, 4'b0100);
        valid_s = '0;
        cycle();
        check("t1_pulse", bus.o_pc_valid, 1'b1);
        check("t1_inflight", bus.o_inflight, 3'd1);
        cycle();
        check("t1_pulse_end", bus.o_pc_valid, 1'b0);
        get_result(rand_result(64'h0));
        check("t1_valid", bus.o_valid, 1'b1);
        check("t1_nonce", bus.o_nonce, 7'h15);
        check("t1_src", bus.o_src_id, 2'd2);
        check("t1_inflight0", bus.o_inflight, 3'd0);
        cycle();

        // Fairness with every core requesting
        do_reset();
        grants.delete();
        valid_s = '1;
        for (int i = 0; i < N_REQ; i++) core_data[i] = rand_state();
        for (int n = 0; n < 60 && grants.size() < 6; n++) begin
            pcv_s = (m_q.size() > 0); res_s = rand_result(tgt_s);
            cycle();
        end
        check("rr_count", grants.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < grants.size(); i++) check("rr_order", grants[i], i % N_REQ);

        // Backpressure: no results come back
        do_reset();
        grants.delete();
        valid_s = '1;
        for (int n = 0; n < 14; n++) cycle();
        check("bp_issues", grants.size(), 4);
        check("bp_inflight", bus.o_inflight, 3'd4);
        check("bp_ready", bus.o_req_ready, 4'b0000);
        grants.delete();
        pcv_s = 1'b1; res_s = rand_result(64'h0);
        cycle();
        pcv_s = 1'b0;
        for (int n = 0; n < 10; n++) cycle();
        check("bp_one_more", grants.size(), 1);

        // Target compare
        do_reset();
        tgt_s = 64'h0000_1000_0000_0000;
        issue_one(1, 7'h22);
        res_s = rand_result(64'h0); res_s[255:192] = 64'h0000_0FFF_FFFF_FFFF;
        get_result(res_s);
        check("tgt_below_valid", bus.o_valid, 1'b1);
        check("tgt_below_found", bus.o_found, 1'b1);
        cycle();
        issue_one(3, 7'h33);
        res_s = rand_result(64'h0); res_s[255:192] = 64'h0000_1000_0000_0000;
        get_result(res_s);
`ifdef POST_CN_SCHED_FOUND_FILTER_EN
        check("tgt_equal_filtered", bus.o_valid, 1'b0);
        check("tgt_equal_inflight", bus.o_inflight, 3'd0);
`else
        check("tgt_equal_valid", bus.o_valid, 1'b1);
        check("tgt_equal_found", bus.o_found, 1'b0);
`endif
        for (int n = 0; n < 3; n++) cycle();

        // Result with nothing outstanding, then in-order tag return
        do_reset();
        pcv_s = 1'b1; res_s = rand_result(64'h0);
        cycle();
        pcv_s = 1'b0;
        cycle();
        check("err_set", bus.o_err, 1'b1);
        check("err_no_valid", bus.o_valid, 1'b0);
        tgt_s = '1;
        issue_one(0, 7'd1);
        issue_one(1, 7'd2);
        issue_one(0, 7'd3);
        for (int j = 0; j < 3; j++) begin
            get_result(rand_result(64'h0));
            check("ord_nonce", bus.o_nonce, NONCE_W'(j + 1));
            check("ord_src", bus.o_src_id, (j == 1) ? 2'd1 : 2'd0);
            cycle();
        end

        // Asynchronous reset with jobs outstanding and a result held
        do_reset();
        tgt_s = '1;
        for (int c = 0; c < 4; c++) issue_one(c, NONCE_W'(c + 8));
        rdy_s = 1'b0;
        get_result(rand_result(64'h0));
        check("ar_valid", bus.o_valid, 1'b1);
        check("ar_inflight", bus.o_inflight, 3'd3);
        #2 rstn = 1'b0;
        #1 reset_checks("async");
        clear_inputs();
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        valid_s = '1;
        cycle();
        check("ar_first_grant", bus.o_req_ready, 4'b0001);

        // Randomized traffic
        do_reset();
        tgt_s = {$urandom, $urandom};
        for (int n = 0; n < 1500; n++) begin
            if (last_grant >= 0) valid_s[last_grant] = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid_s[i] && $urandom_range(0, 3) == 0) begin
                    valid_s[i] = 1'b1; core_data[i] = rand_state(); core_nonce[i] = NONCE_W'($urandom);
                end else if (valid_s[i] && i != last_grant && $urandom_range(0, 31) == 0)
                    valid_s[i] = 1'b0;
            end
            pcr_s = ($urandom_range(0, 4) != 0);
            if (!(pcv_s && !last_pc_taken)) begin
                pcv_s = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 299) == 0);
                res_s = rand_result(tgt_s);
            end
            rdy_s = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) tgt_s = {$urandom, $urandom};
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
